// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, branch squash,
// multi-cycle MUL/DIV and data-memory wait handling, plus perf counters.
module pipeline_hazard_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1_addr,
  input  logic [4:0]       if_id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd_addr,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_is_mdu,
  input  logic             ex_branch_taken,
  input  logic             mdu_done,
  input  logic             ex_mem_mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mdu_start,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
  logic              mem_stall, load_use, br_flush;

  // EX/MEM only holds a bubble during MDU_WAIT, so a memory request there is stale.
  assign mem_stall = (state_q != MDU_WAIT) & ex_mem_mem_req & ~dmem_ready;

  assign load_use = id_ex_mem_read & (id_ex_rd_addr != 5'd0) &
                    ((id_uses_rs1 & (if_id_rs1_addr == id_ex_rd_addr)) |
                     (id_uses_rs2 & (if_id_rs2_addr == id_ex_rd_addr)));

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_start     = 1'b0;
    br_flush      = 1'b0;
    state_d       = RUN;
    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (state_q == MDU_WAIT) begin
      if (!mdu_done) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        state_d       = MDU_WAIT;
      end
    end else begin
      // RUN and MEM_WAIT share one decision tree: leaving MEM_WAIT costs no cycle.
      if (mem_stall) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        state_d   = MEM_WAIT;
      end else if (id_ex_is_mdu) begin
        mdu_start     = 1'b1;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        state_d       = MDU_WAIT;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        br_flush    = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    wait_d    = mem_stall ? ((wait_q == WAIT_LAST) ? wait_q : wait_q + 1'b1) : '0;
    timeout_d = timeout_q | (mem_stall & (wait_q == WAIT_LAST));
    stall_d   = (!pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d   = (br_flush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench for pipeline_hazard_controller against a cycle-level behavioural model.
module tb_pipeline_hazard_controller;
  localparam int CNT_W = 4;
  localparam int MT    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble, mdu_start}
  localparam logic [8:0] O_IDLE  = 9'b11111_000_0;
  localparam logic [8:0] O_FRZ   = 9'b00000_000_0;
  localparam logic [8:0] O_MDUS  = 9'b00011_001_1;
  localparam logic [8:0] O_MDUW  = 9'b00011_001_0;
  localparam logic [8:0] O_BR    = 9'b11111_110_0;
  localparam logic [8:0] O_LU    = 9'b00111_010_0;
  localparam logic [8:0] O_RST   = 9'b00000_111_0;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       ld, mdu, br, done, req, rdy;
  } stim_t;

  logic clk = 0, rst = 1;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, ld, mdu, br, done, req, rdy;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_bubble, mdu_start, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int nvec = 0, nerr = 0;
  bit m_busy, m_to;
  int m_stall, m_flush, m_wait;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs1_addr(rs1), .if_id_rs2_addr(rs2), .id_uses_rs1(u1), .id_uses_rs2(u2),
    .id_ex_rd_addr(rd), .id_ex_mem_read(ld), .id_ex_is_mdu(mdu),
    .ex_branch_taken(br), .mdu_done(done), .ex_mem_mem_req(req), .dmem_ready(rdy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .mdu_start(mdu_start), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  function automatic logic [8:0] ctl_now();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_bubble, mdu_start};
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  // Reference: what the spec's priority rules demand for this cycle.
  function automatic logic [8:0] ref_ctl(bit busy, stim_t s);
    bit hazard;
    if (busy) return s.done ? O_IDLE : O_MDUW;
    if (s.req && !s.rdy) return O_FRZ;
    if (s.mdu) return O_MDUS;
    if (s.br) return O_BR;
    hazard = s.ld && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    return hazard ? O_LU : O_IDLE;
  endfunction

  task automatic drive(stim_t s);
    rs1 = s.rs1; rs2 = s.rs2; u1 = s.u1; u2 = s.u2; rd = s.rd;
    ld = s.ld; mdu = s.mdu; br = s.br; done = s.done; req = s.req; rdy = s.rdy;
  endtask

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  // Called at posedge+1: apply, check mid-cycle, then advance model across the edge.
  task automatic step(stim_t s, string tag);
    logic [8:0] e;
    bit stalled;
    drive(s);
    #3;
    e = ref_ctl(m_busy, s);
    nvec++;
    if (ctl_now() !== e) begin
      nerr++; $display("FAIL %s ctl got %b want %b", tag, ctl_now(), e);
    end
    nvec++;
    if (stall_cycles !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush) || mem_timeout !== m_to) begin
      nerr++;
      $display("FAIL %s cnt got stall=%0d flush=%0d to=%b want %0d %0d %b",
               tag, stall_cycles, flush_count, mem_timeout, m_stall, m_flush, m_to);
    end
    @(posedge clk);
    stalled = !m_busy && s.req && !s.rdy;
    if (!e[8] && m_stall < CMAX) m_stall++;
    if (e == O_BR && m_flush < CMAX) m_flush++;
    if (stalled) begin
      m_wait++;
      if (m_wait >= MT) m_to = 1;
    end else m_wait = 0;
    m_busy = m_busy ? !s.done : (!stalled && s.mdu);
    #1;
  endtask

  task automatic chk(string tag, int got, int want);
    nvec++;
    if (got !== want) begin
      nerr++; $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic do_reset();
    drive(idle());
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    drive(idle());
    rst = 1;
    #2;
    chk("reset_ctl", int'(ctl_now()), int'(O_RST));
    chk("reset_cnt", int'({stall_cycles, flush_count, mem_timeout}), 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    step(idle(), "post_reset_idle");
  endtask

  task automatic test_load_use();
    stim_t s;
    do_reset();
    s = idle(); s.ld = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; s.rs2 = 7; s.u2 = 1;
    step(s, "lu_stall");
    step(idle(), "lu_after");
    chk("lu_stall_cycles", int'(stall_cycles), 1);
    s.rd = 0; s.rs1 = 0;
    step(s, "lu_x0");
    chk("lu_x0_pc_en", int'(pc_en), 1);
    s = idle(); s.ld = 1; s.rd = 9; s.rs2 = 9; s.u2 = 1; s.rs1 = 9; s.u1 = 0;
    step(s, "lu_rs2");
    s.u2 = 0;
    step(s, "lu_unused");
  endtask

  task automatic test_branch();
    stim_t s;
    do_reset();
    s = idle(); s.br = 1;
    step(s, "br");
    step(idle(), "br_after");
    chk("br_flush_count", int'(flush_count), 1);
  endtask

  task automatic test_mdu();
    stim_t s;
    do_reset();
    s = idle(); s.mdu = 1;
    step(s, "mdu_start");
    for (int i = 0; i < 4; i++) begin
      s.req = i[0]; s.rdy = 0;
      step(s, "mdu_wait");
    end
    s = idle(); s.mdu = 1; s.done = 1;
    step(s, "mdu_done");
    chk("mdu_stall_cycles", int'(stall_cycles), 5);
    s.done = 0;
    step(s, "mdu_restart");
  endtask

  task automatic test_mem_wait();
    stim_t s;
    do_reset();
    s = idle(); s.req = 1; s.rdy = 0; s.br = 1;
    for (int i = 0; i < 3; i++) step(s, "mem_freeze");
    chk("mem_no_flush_yet", int'(flush_count), 0);
    s.rdy = 1;
    step(s, "mem_exit_branch");
    chk("mem_flush_count", int'(flush_count), 1);
    chk("mem_stall_cycles", int'(stall_cycles), 3);
  endtask

  task automatic test_timeout();
    stim_t s;
    do_reset();
    s = idle(); s.req = 1; s.rdy = 0;
    for (int i = 0; i < 3; i++) step(s, "to_wait");
    chk("to_not_yet", int'(mem_timeout), 0);
    step(s, "to_wait4");
    chk("to_set", int'(mem_timeout), 1);
    s.rdy = 1;
    step(s, "to_ready");
    chk("to_sticky", int'(mem_timeout), 1);
  endtask

  task automatic test_reset_mid_mdu();
    stim_t s;
    do_reset();
    s = idle(); s.mdu = 1;
    step(s, "rmdu_start");
    step(s, "rmdu_wait");
    #1 rst = 1;
    #1;
    chk("rmdu_async_ctl", int'(ctl_now()), int'(O_RST));
    chk("rmdu_async_cnt", int'(stall_cycles), 0);
    drive(idle());
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    step(idle(), "rmdu_run");
    chk("rmdu_pc_en", int'(pc_en), 1);
  endtask

  task automatic test_random();
    stim_t s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.u1 = 1'($urandom_range(0, 1)); s.u2 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        2: s.ld = 1;
        3: s.mdu = 1;
        4: s.br = 1;
        default: ;
      endcase
      s.req  = ($urandom_range(0, 2) == 0);
      s.rdy  = 1'($urandom_range(0, 1));
      s.done = ($urandom_range(0, 3) == 0);
      step(s, "rand");
    end
    chk("rand_stall_sat", int'(stall_cycles), CMAX);
  endtask

  initial begin
    drive(idle());
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_mdu();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
